// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and sizing helpers.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arb_state_t;

    localparam int MAX_PORTS = 8;
    localparam int CNT_W     = 3;

    // Port-id width; a single bit is kept even when only one id value exists.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side and memory-side buses of the arbiter bundled in one interface.
interface dmem_arbiter_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32
);
    logic [NUM_PORTS-1:0]        req;
    logic [NUM_PORTS-1:0]        req_we;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr;
    logic [NUM_PORTS*DATA_W-1:0] req_wd;
    logic [NUM_PORTS-1:0]        ack;
    logic [DATA_W-1:0]           rd_data;
    logic                        busy;
    logic                        mem_en;
    logic                        mem_we;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wd;
    logic [DATA_W-1:0]           mem_rd;

    // master: requesters plus the memory; slave: the arbiter itself
    modport master (
        output req, req_we, req_addr, req_wd, mem_rd,
        input  ack, rd_data, busy, mem_en, mem_we, mem_addr, mem_wd
    );
    modport slave (
        input  req, req_we, req_addr, req_wd, mem_rd,
        output ack, rd_data, busy, mem_en, mem_we, mem_addr, mem_wd
    );
endinterface

// File: rtl/dmem_arbiter_rr_select.sv
// Round-robin winner select: rotate req by rr_ptr, then take the lowest asserted offset.
module dmem_arbiter_rr_select #(
    parameter int NUM_PORTS = 2,
    parameter int ID_W      = 1
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [ID_W-1:0]      rr_ptr_i,
    output logic [ID_W-1:0]      winner_o,
    output logic                 any_req_o
);
    logic [ID_W-1:0]      idx_arr [NUM_PORTS];
    logic [NUM_PORTS-1:0] rot;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_rot
        logic [ID_W:0] sum;
        logic [ID_W:0] wrapped;
        assign sum          = {1'b0, rr_ptr_i} + (ID_W+1)'(gi);
        assign wrapped      = (sum >= (ID_W+1)'(NUM_PORTS)) ? sum - (ID_W+1)'(NUM_PORTS) : sum;
        assign idx_arr[gi]  = wrapped[ID_W-1:0];
        assign rot[gi]      = req_i[idx_arr[gi]];
    end

    always_comb begin
        winner_o = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (rot[i]) winner_o = idx_arr[i];
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/dmem_arbiter.sv
// N-port round-robin arbiter sharing one single-ported data memory with a
// req/ack handshake and configurable memory read latency.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 0
) (
    input  logic           clock,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    localparam int ID_W = id_width(NUM_PORTS);
    localparam logic [CNT_W-1:0] CNT_INIT = (RD_LATENCY > 0) ? CNT_W'(RD_LATENCY - 1) : '0;

    arb_state_t         state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wd_q, wd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    logic [ID_W-1:0]    winner;
    logic               any_req;

    dmem_arbiter_rr_select #(
        .NUM_PORTS (NUM_PORTS),
        .ID_W      (ID_W)
    ) u_rr_select (
        .req_i     (bus.req),
        .rr_ptr_i  (rr_ptr_q),
        .winner_o  (winner),
        .any_req_o (any_req)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wd_q     <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wd_q     <= wd_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wd_d     = wd_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    id_d     = winner;
                    we_d     = bus.req_we[winner];
                    addr_d   = bus.req_addr[int'(winner)*ADDR_W +: ADDR_W];
                    wd_d     = bus.req_wd[int'(winner)*DATA_W +: DATA_W];
                    rr_ptr_d = (winner == ID_W'(NUM_PORTS - 1)) ? '0 : winner + 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q || RD_LATENCY == 0) begin
                    if (!we_q) rdata_d = bus.mem_rd;
                    state_d = ACK;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d = bus.mem_rd;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory strobes are decoded from state so an async reset kills them at once.
    assign bus.mem_en   = (state_q == ISSUE);
    assign bus.mem_we   = (state_q == ISSUE) && we_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_wd   = wd_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.rd_data  = rdata_q;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ack
        assign bus.ack[gi] = (state_q == ACK) && (id_q == ID_W'(gi));
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: three arbiter configurations (2p/lat0, 2p/lat3, 4p/lat2) with memory models.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_arbiter_if #(.NUM_PORTS(2), .ADDR_W(10), .DATA_W(32)) bus_a ();
    dmem_arbiter_if #(.NUM_PORTS(2), .ADDR_W(10), .DATA_W(32)) bus_b ();
    dmem_arbiter_if #(.NUM_PORTS(4), .ADDR_W(10), .DATA_W(32)) bus_c ();

    dmem_arbiter #(.NUM_PORTS(2), .ADDR_W(10), .DATA_W(32), .RD_LATENCY(0))
        u_a (.clock(clk), .reset(rst), .bus(bus_a));
    dmem_arbiter #(.NUM_PORTS(2), .ADDR_W(10), .DATA_W(32), .RD_LATENCY(3))
        u_b (.clock(clk), .reset(rst), .bus(bus_b));
    dmem_arbiter #(.NUM_PORTS(4), .ADDR_W(10), .DATA_W(32), .RD_LATENCY(2))
        u_c (.clock(clk), .reset(rst), .bus(bus_c));

    // Memory A: combinational read, writable, with a bench preload port
    logic [31:0] mem_a [1024];
    logic        pl_we = 1'b0;
    logic [9:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;
    always @(posedge clk) begin
        if (pl_we) mem_a[pl_addr] <= pl_data;
        else if (bus_a.mem_en && bus_a.mem_we) mem_a[bus_a.mem_addr] <= bus_a.mem_wd;
    end
    assign bus_a.mem_rd = mem_a[bus_a.mem_addr];

    // Memories B and C: read-only, content = tag | addr, poisoned when not enabled
    logic [31:0] pipe_b [3];
    always @(posedge clk) begin
        pipe_b[0] <= bus_b.mem_en ? (32'hB0B00000 | 32'(bus_b.mem_addr)) : 32'hBAD0BAD0;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign bus_b.mem_rd = pipe_b[2];

    logic [31:0] pipe_c [2];
    always @(posedge clk) begin
        pipe_c[0] <= bus_c.mem_en ? (32'hC0DE0000 | 32'(bus_c.mem_addr)) : 32'hBAD0BAD0;
        pipe_c[1] <= pipe_c[0];
    end
    assign bus_c.mem_rd = pipe_c[1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_cmp++; if (bus_a.ack !== 2'b00) begin n_bad++; $display("FAIL reset_ack: got %b want 00", bus_a.ack); end
        n_cmp++; if (bus_a.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus_a.busy); end
        n_cmp++; if (bus_a.rd_data !== 32'h0) begin n_bad++; $display("FAIL reset_rd_data: got %h want 0", bus_a.rd_data); end
        n_cmp++; if (bus_a.mem_en !== 1'b0 || bus_a.mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_strobes: got en=%b we=%b want 0/0", bus_a.mem_en, bus_a.mem_we); end
        n_cmp++; if (bus_a.mem_addr !== 10'h0 || bus_a.mem_wd !== 32'h0) begin n_bad++; $display("FAIL reset_mem_bus: got addr=%h wd=%h want 0/0", bus_a.mem_addr, bus_a.mem_wd); end
        n_cmp++; if (u_c.rr_ptr_q !== 2'd0) begin n_bad++; $display("FAIL reset_rr_ptr: got %0d want 0", u_c.rr_ptr_q); end
        $display("test_reset: done");
    endtask

    task automatic test_single_read();
        pl_we = 1'b1; pl_addr = 10'h004; pl_data = 32'hDEADBEEF;
        tick();
        pl_we = 1'b0;
        bus_a.req_we = 2'b00;
        bus_a.req_addr[0 +: 10] = 10'h004;
        bus_a.req = 2'b01;
        tick();
        n_cmp++; if (bus_a.mem_en !== 1'b1 || bus_a.mem_addr !== 10'h004) begin n_bad++; $display("FAIL read_issue: got en=%b addr=%h want 1/004", bus_a.mem_en, bus_a.mem_addr); end
        n_cmp++; if (bus_a.ack !== 2'b00) begin n_bad++; $display("FAIL read_early_ack: got %b want 00", bus_a.ack); end
        tick();
        n_cmp++; if (bus_a.ack !== 2'b01) begin n_bad++; $display("FAIL read_ack: got %b want 01", bus_a.ack); end
        n_cmp++; if (bus_a.rd_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL read_data: got %h want deadbeef", bus_a.rd_data); end
        bus_a.req = 2'b00;
        tick();
        n_cmp++; if (bus_a.ack !== 2'b00 || bus_a.busy !== 1'b0) begin n_bad++; $display("FAIL read_idle: got ack=%b busy=%b want 00/0", bus_a.ack, bus_a.busy); end
        $display("test_single_read: port0 addr 004 rd_data=%h", bus_a.rd_data);
    endtask

    task automatic test_latency3();
        bus_b.req_we = 2'b00;
        bus_b.req_addr[10 +: 10] = 10'h010;
        bus_b.req = 2'b10;
        for (int c = 1; c <= 6; c++) begin
            tick();
            n_cmp++; if (bus_b.mem_en !== (c == 1)) begin n_bad++; $display("FAIL lat3_mem_en c%0d: got %b want %b", c, bus_b.mem_en, (c == 1)); end
            n_cmp++; if (bus_b.busy !== (c <= 5)) begin n_bad++; $display("FAIL lat3_busy c%0d: got %b want %b", c, bus_b.busy, (c <= 5)); end
            n_cmp++; if (bus_b.ack !== ((c == 5) ? 2'b10 : 2'b00)) begin n_bad++; $display("FAIL lat3_ack c%0d: got %b", c, bus_b.ack); end
            if (c == 5) begin
                n_cmp++; if (bus_b.rd_data !== 32'hB0B00010) begin n_bad++; $display("FAIL lat3_data: got %h want b0b00010", bus_b.rd_data); end
                bus_b.req = 2'b00;
            end
        end
        $display("test_latency3: port1 addr 010 rd_data=%h", bus_b.rd_data);
    endtask

    task automatic test_write_readback();
        bus_a.req_we = 2'b01;
        bus_a.req_addr[0 +: 10] = 10'h020;
        bus_a.req_wd[0 +: 32] = 32'h12345678;
        bus_a.req = 2'b01;
        tick();
        n_cmp++; if (bus_a.mem_we !== 1'b1 || bus_a.mem_addr !== 10'h020 || bus_a.mem_wd !== 32'h12345678) begin n_bad++; $display("FAIL wr_issue: got we=%b addr=%h wd=%h want 1/020/12345678", bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wd); end
        tick();
        n_cmp++; if (bus_a.ack !== 2'b01 || bus_a.mem_we !== 1'b0) begin n_bad++; $display("FAIL wr_ack: got ack=%b we=%b want 01/0", bus_a.ack, bus_a.mem_we); end
        bus_a.req = 2'b00;
        bus_a.req_we = 2'b00;
        tick();
        bus_a.req_addr[10 +: 10] = 10'h020;
        bus_a.req = 2'b10;
        tick();
        n_cmp++; if (bus_a.mem_we !== 1'b0 || bus_a.mem_addr !== 10'h020) begin n_bad++; $display("FAIL rb_issue: got we=%b addr=%h want 0/020", bus_a.mem_we, bus_a.mem_addr); end
        tick();
        n_cmp++; if (bus_a.ack !== 2'b10) begin n_bad++; $display("FAIL rb_ack: got %b want 10", bus_a.ack); end
        n_cmp++; if (bus_a.rd_data !== 32'h12345678) begin n_bad++; $display("FAIL rb_data: got %h want 12345678", bus_a.rd_data); end
        bus_a.req = 2'b00;
        tick();
        $display("test_write_readback: wrote 12345678 @020, read back %h", bus_a.rd_data);
    endtask

    task automatic test_fairness();
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int n_ack = 0;
        logic [3:0] exp_ack;
        bus_c.req_we = 4'b0000;
        for (int k = 0; k < 4; k++) bus_c.req_addr[k*10 +: 10] = 10'h100 + 10'(k);
        bus_c.req = 4'hF;
        for (int cyc = 1; cyc <= 40 && n_ack < 5; cyc++) begin
            tick();
            if (bus_c.ack !== 4'b0000) begin
                exp_ack = 4'(1 << exp_order[n_ack]);
                n_cmp++; if (bus_c.ack !== exp_ack) begin n_bad++; $display("FAIL fair_order #%0d: got %b want %b", n_ack, bus_c.ack, exp_ack); end
                n_cmp++; if (cyc != 4 + 5*n_ack) begin n_bad++; $display("FAIL fair_timing #%0d: got cycle %0d want %0d", n_ack, cyc, 4 + 5*n_ack); end
                n_cmp++; if (bus_c.rd_data !== (32'hC0DE0100 + 32'(exp_order[n_ack]))) begin n_bad++; $display("FAIL fair_data #%0d: got %h", n_ack, bus_c.rd_data); end
                $display("test_fairness: ack #%0d = %b at cycle %0d", n_ack, bus_c.ack, cyc);
                n_ack++;
                if (n_ack == 5) bus_c.req = 4'h0;
            end
        end
        n_cmp++; if (n_ack != 5) begin n_bad++; $display("FAIL fair_timeout: got %0d acks want 5", n_ack); end
        bus_c.req = 4'h0;
        tick();
    endtask

    task automatic test_dropped();
        bus_c.req_we = 4'b0000;
        bus_c.req_addr[20 +: 10] = 10'h222;
        bus_c.req = 4'b0100;
        tick();
        n_cmp++; if (bus_c.mem_en !== 1'b1 || bus_c.mem_addr !== 10'h222) begin n_bad++; $display("FAIL drop_issue: got en=%b addr=%h want 1/222", bus_c.mem_en, bus_c.mem_addr); end
        bus_c.req = 4'b0000;
        bus_c.req_addr[20 +: 10] = 10'h333;
        for (int c = 2; c <= 7; c++) begin
            tick();
            n_cmp++; if (bus_c.ack !== ((c == 4) ? 4'b0100 : 4'b0000)) begin n_bad++; $display("FAIL drop_ack c%0d: got %b", c, bus_c.ack); end
            if (c == 4) begin
                n_cmp++; if (bus_c.rd_data !== 32'hC0DE0222) begin n_bad++; $display("FAIL drop_data: got %h want c0de0222", bus_c.rd_data); end
            end
        end
        $display("test_dropped: port2 completed with rd_data=%h", bus_c.rd_data);
    endtask

    task automatic test_reset_mid();
        bus_c.req_we = 4'b0000;
        bus_c.req_addr[30 +: 10] = 10'h0AB;
        bus_c.req = 4'b1000;
        tick();
        tick();
        n_cmp++; if (u_c.state_q !== WAIT) begin n_bad++; $display("FAIL rst_pre_state: got %0d want %0d", u_c.state_q, WAIT); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus_c.ack !== 4'b0000 || bus_c.busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ack: got ack=%b busy=%b want 0000/0", bus_c.ack, bus_c.busy); end
        n_cmp++; if (bus_c.mem_en !== 1'b0 || bus_c.mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mid_strobes: got en=%b we=%b want 0/0", bus_c.mem_en, bus_c.mem_we); end
        n_cmp++; if (u_c.state_q !== IDLE || u_c.rr_ptr_q !== 2'd0) begin n_bad++; $display("FAIL rst_mid_state: got state=%0d rr=%0d want 0/0", u_c.state_q, u_c.rr_ptr_q); end
        bus_c.req = 4'b0001;
        bus_c.req_addr[0 +: 10] = 10'h055;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            n_cmp++; if (bus_c.ack !== ((c == 4) ? 4'b0001 : 4'b0000) || bus_c.mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_after c%0d: got ack=%b we=%b", c, bus_c.ack, bus_c.mem_we); end
            if (c == 4) begin
                n_cmp++; if (bus_c.rd_data !== 32'hC0DE0055) begin n_bad++; $display("FAIL rst_after_data: got %h want c0de0055", bus_c.rd_data); end
                bus_c.req = 4'b0000;
            end
        end
        $display("test_reset_mid: port0 serviced after reset, rd_data=%h", bus_c.rd_data);
    endtask

    initial begin
        bus_a.req = '0; bus_a.req_we = '0; bus_a.req_addr = '0; bus_a.req_wd = '0;
        bus_b.req = '0; bus_b.req_we = '0; bus_b.req_addr = '0; bus_b.req_wd = '0;
        bus_c.req = '0; bus_c.req_we = '0; bus_c.req_addr = '0; bus_c.req_wd = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_single_read();
        test_latency3();
        test_write_readback();
        test_fairness();
        test_dropped();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Parametrised N-port round-robin arbiter that shares one single-ported data memory between several requesters (multiple mips cores, or a core plus a DMA/debug master).
- Next generation of the system-level memory hookup: the old direct dmem wiring is replaced by a request/acknowledge handshake with configurable memory read latency and data/address widths.
- Sits between the per-core dmem_we/alu_out/dmem_wd/dmem_rd buses and the dmem instance.

Parameters:
- NUM_PORTS, 2, number of requesters (2..8)
- ADDR_W, 10, memory word-address width
- DATA_W, 32, data width
- RD_LATENCY, 0, memory read latency in cycles after the issue cycle (0 = combinational dmem, 1..7 = registered RAM)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_PORTS  per-port request, held high until ack
- req_we  in  NUM_PORTS  per-port write enable (1 = write)
- req_addr  in  NUM_PORTS*ADDR_W  packed per-port addresses, port k at [k*ADDR_W +: ADDR_W]
- req_wd  in  NUM_PORTS*DATA_W  packed per-port write data
- ack  out  NUM_PORTS  one-hot, one-cycle completion pulse
- rd_data  out  DATA_W  read data, valid while ack is high (shared by all ports)
- busy  out  1  high in every state except IDLE
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wd  out  DATA_W  memory write data
- mem_rd  in  DATA_W  memory read data

Behaviour:
- Reset: state=IDLE, rr_ptr=0, ack=0, rd_data=0, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wd=0. The asynchronous assertion aborts any in-flight access immediately. No ack and no further mem_we are produced for that access.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE: if req != 0, select the winner as the first asserted port scanning rr_ptr, rr_ptr+1, … wrapping mod NUM_PORTS.
  - Latch the winner's id, we, addr and wd into registers.
  - Set rr_ptr = (winner+1) mod NUM_PORTS.
  - Go to ISSUE. If req == 0, stay in IDLE.
- ISSUE (1 cycle): mem_en=1, mem_we=latched we, mem_addr and mem_wd driven from the latched registers.
  - Write: memory commits at the end of ISSUE; go to ACK.
  - Read with RD_LATENCY=0: capture mem_rd at the end of ISSUE; go to ACK.
  - Read with RD_LATENCY>0: go to WAIT.
- WAIT: mem_en=0, mem_addr held. A down-counter loaded with RD_LATENCY-1 runs; capture mem_rd at the end of the cycle in which the counter is 0, then go to ACK.
- ACK (1 cycle): ack[id]=1, rd_data = captured value (writes present the previous rd_data, don't-care), then return to IDLE.
- Latency from req seen in IDLE (cycle 0) to ack: writes at cycle 2; reads at cycle 2+RD_LATENCY. Throughput is one access per 3+RD_LATENCY cycles (reads) or 3 cycles (writes).
- req/addr/wd changes after the grant are ignored. A req dropped before ack is still completed and acked.
- A port holding req high across its ack is treated as a new request in the following IDLE cycle. rr_ptr has already moved past it, so other pending ports win first.
- Only the granted port ever sees ack. ack is never asserted for two ports at once.
- mem_we=1 only in ISSUE, and only for a latched write.
- Simultaneous requests from all ports are serviced in strict rotation starting at rr_ptr.

Decomposition:
- global_types package gets:
  - the state enum arb_state_t {IDLE, ISSUE, WAIT, ACK}
  - the localparam-derived port-id width, $clog2(NUM_PORTS) (min 1)
- One sub-module, rr_select: combinational rotate/priority-encode of req by rr_ptr, outputs winner id and any_req.
- The pointer register stays in dmem_arbiter.

Test Plan:
- Single read, NUM_PORTS=2, RD_LATENCY=0: port0 reads addr 0x004 (mem holds 0xDEADBEEF) -> mem_en at cycle 1, ack=2'b01 at cycle 2, rd_data=0xDEADBEEF.
- RD_LATENCY=3, port1 reads addr 0x010 -> ack=2'b10 at cycle 5, busy high cycles 1-5, mem_en only in cycle 1.
- Write then read-back: port0 writes 0x12345678 to 0x020 -> ack at cycle 2; port1 then reads 0x020 -> rd_data=0x12345678.
- Fairness, NUM_PORTS=4: all four req held high continuously -> ack order p0,p1,p2,p3,p0; no port acked twice before all others acked once.
- Reset mid-access: assert reset during WAIT of a read (RD_LATENCY=2) -> ack stays 0, state IDLE, mem_en/mem_we=0, rr_ptr=0. After release, a pending port0 req is serviced normally.
- Dropped request: port2 req falls the cycle after grant -> access still issued, ack[2] pulses; no other ack generated.
